// File: rtl/alu_pkg.sv
// Shared definitions for the sequential bus ALU: opcodes, flag bit positions, FSM states.
// No logic here; imported by alu_seq and alu_mul_seq.
// Opcodes 0-3 keep the legacy 2-bit ALU encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_INC = 4'd2;
  localparam logic [3:0] OP_DEC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_ASR = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  // Bit positions inside the {N,V,C,Z} flag register
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one partial product per clock.
// Latency: go at edge N, product valid (comb) and done high during the cycle ending at edge N+WIDTH.
// No backpressure: go is ignored while busy; the caller must capture product when done is high.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               last_iter;

  // The final iteration's sum is handed out combinationally so the top can
  // write it at the same edge the multiplier goes idle.
  assign last_iter = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign busy      = busy_q;
  assign done      = last_iter;
  assign product   = acc_d;

  // Next state: load operands on go, otherwise add-and-shift one bit per cycle
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (last_iter) begin
        busy_d = 1'b0;
      end
    end else if (go) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end
  end

  // Iteration state; reset aborts any multiply in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Bus ALU: A from accumulator, B from shared bus, registered result driven back on out_en.
// Latency: single-cycle ops done one cycle after the start edge; MUL done WIDTH edges after start.
// No backpressure: start is dropped while a multiply is busy; the bus read is combinational.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             out_en,
  input  logic             hi_sel,
  input  logic [WIDTH-1:0] acc_in,
  inout  wire  [WIDTH-1:0] data_bus,
  output logic             busy,
  output logic             done,
  output logic [3:0]       flags
);

  localparam int SHAMT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e state_q, state_d;

  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;

  logic             accept, mul_go, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] bus_drive, a, b;
  logic [SHAMT_W-1:0] sh;
  logic             sh_big;
  logic [WIDTH:0]   sum_w, diff_w, shl_w, shr_w, asr_w;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_wr;

  // Bus is driven straight from the registers; it keeps showing the last
  // completed result for the whole multiply.
  assign bus_drive = hi_sel ? result_hi_q : result_q;
  assign data_bus  = out_en ? bus_drive : 'z;

  // When we are driving the bus ourselves, B is our own result (chaining).
  assign a      = acc_in;
  assign b      = out_en ? bus_drive : data_bus;
  assign sh     = b[SHAMT_W-1:0];
  assign sh_big = (sh >= SHAMT_W'(WIDTH));

  // Extra bit on top carries C for add/sub/shl; extra bit at the bottom
  // catches the last bit shifted out for right shifts.
  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};
  assign shl_w  = {1'b0, a} << sh;
  assign shr_w  = {a, 1'b0} >> sh;
  assign asr_w  = $signed({a, 1'b0}) >>> sh;

  assign busy  = mul_busy;
  assign done  = done_q;
  assign flags = flags_q;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .go      (mul_go),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: stay in MUL until the multiplier's last iteration
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && (op == OP_MUL)) state_d = ST_MUL;
      ST_MUL:  if (mul_done)                state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: requests are only taken while idle
  always_comb begin
    accept = (state_q == ST_IDLE) && start;
    mul_go = accept && (op == OP_MUL);
  end

  // Single-cycle datapath: result plus C and V for the current opcode
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_wr  = 1'b1;
    case (op)
      OP_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_w[WIDTH-1:0];
        alu_c   = diff_w[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_INC: begin
        alu_res = b + WIDTH'(1);
        alu_c   = &b;
        alu_v   = (b == MAX_POS);
      end
      OP_DEC: begin
        alu_res = b - WIDTH'(1);
        alu_c   = (b == '0);
        alu_v   = (b == MIN_NEG);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~b;
      OP_SHL: begin
        alu_res = sh_big ? '0 : shl_w[WIDTH-1:0];
        alu_c   = sh_big ? 1'b0 : shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res = sh_big ? '0 : shr_w[WIDTH:1];
        alu_c   = sh_big ? 1'b0 : shr_w[0];
      end
      OP_ASR: begin
        alu_res = sh_big ? {WIDTH{a[WIDTH-1]}} : asr_w[WIDTH:1];
        alu_c   = sh_big ? a[WIDTH-1] : asr_w[0];
      end
      default: alu_wr = 1'b0;  // MUL is handled by the multiplier; 12-15 only pulse done
    endcase
  end

  // Completion: pick multiplier or single-cycle result and set flags
  always_comb begin
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    done_d      = 1'b0;
    if (mul_done) begin
      {result_hi_d, result_d} = mul_product;
      flags_d          = '0;
      flags_d[FLAG_N]  = mul_product[2*WIDTH-1];
      flags_d[FLAG_Z]  = (mul_product == '0);
      flags_d[FLAG_C]  = |mul_product[2*WIDTH-1:WIDTH];
      done_d           = 1'b1;
    end else if (accept && !mul_go) begin
      done_d = 1'b1;
      if (alu_wr) begin
        result_d        = alu_res;
        flags_d[FLAG_N] = alu_res[WIDTH-1];
        flags_d[FLAG_V] = alu_v;
        flags_d[FLAG_C] = alu_c;
        flags_d[FLAG_Z] = (alu_res == '0);
      end
    end
  end

  // Result, flag and done registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8) with an arithmetic reference model.
// Inputs change 2ns after the rising edge; outputs are compared on the falling edge.
// Each directed op also checks hand-computed literals against both DUT and model.
module tb_alu_seq;

  localparam int W    = 8;
  localparam int FULL = 1 << W;
  localparam int MASK = FULL - 1;
  localparam int HALF = 1 << (W - 1);

  logic         clk;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic         out_en;
  logic         hi_sel;
  logic [W-1:0] acc;
  logic [W-1:0] tb_drv;
  logic         tb_en;
  wire  [W-1:0] data_bus;
  logic         busy;
  logic         done;
  logic [3:0]   flags;

  int n_chk  = 0;
  int n_fail = 0;
  logic checking = 1'b0;

  assign data_bus = tb_en ? tb_drv : 'z;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .out_en   (out_en),
    .hi_sel   (hi_sel),
    .acc_in   (acc),
    .data_bus (data_bus),
    .busy     (busy),
    .done     (done),
    .flags    (flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_res = 0, m_hi = 0, m_cnt = 0, m_pa = 0, m_pb = 0;
  logic [3:0] m_flags = 4'h0;
  logic m_done = 1'b0, m_busy = 1'b0;
  int prod, bval;
  logic [11:0] mr;

  // Returns {flags{N,V,C,Z}, result} from plain integer arithmetic
  function automatic logic [11:0] model_op(int opc, int a, int b);
    int r, sa, sb, sh;
    logic fc, fv;
    r = 0; fc = 1'b0; fv = 1'b0;
    sh = b % (2 * W);
    sa = (a >= HALF) ? a - FULL : a;
    sb = (b >= HALF) ? b - FULL : b;
    case (opc)
      0: begin r = a + b; fc = (r >= FULL); fv = (sa + sb > HALF - 1) || (sa + sb < -HALF); end
      1: begin r = a - b; fc = (a < b);     fv = (sa - sb > HALF - 1) || (sa - sb < -HALF); end
      2: begin r = b + 1; fc = (b == MASK); fv = (b == HALF - 1); end
      3: begin r = b - 1; fc = (b == 0);    fv = (b == HALF); end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: r = ~b;
      8: if (sh == 0) r = a; else if (sh >= W) r = 0;
         else begin r = a << sh; fc = ((a >> (W - sh)) & 1) != 0; end
      9: if (sh == 0) r = a; else if (sh >= W) r = 0;
         else begin r = a >> sh; fc = ((a >> (sh - 1)) & 1) != 0; end
      10: if (sh == 0) r = a;
          else if (sh >= W) begin r = (sa < 0) ? MASK : 0; fc = (sa < 0); end
          else begin r = sa >>> sh; fc = ((a >> (sh - 1)) & 1) != 0; end
      default: r = 0;
    endcase
    r = r & MASK;
    return {r[W-1], fv, fc, (r == 0), r[7:0]};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_res = 0; m_hi = 0; m_flags = 4'h0; m_done = 1'b0; m_busy = 1'b0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          prod    = m_pa * m_pb;
          m_hi    = prod >> W;
          m_res   = prod & MASK;
          m_flags = {m_hi[W-1], 1'b0, (m_hi != 0), (prod == 0)};
          m_busy  = 1'b0;
          m_done  = 1'b1;
        end
      end else if (start) begin
        bval = out_en ? (hi_sel ? m_hi : m_res) : int'(tb_drv);
        if (op == 4'd11) begin
          m_busy = 1'b1; m_cnt = W; m_pa = int'(acc); m_pb = bval;
        end else begin
          m_done = 1'b1;
          if (op < 4'd11) begin
            mr      = model_op(int'(op), int'(acc), bval);
            m_res   = int'(mr[7:0]);
            m_flags = mr[11:8];
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  logic [W-1:0] bus_z = 'z;
  always @(negedge clk) begin
    if (checking) begin
      check("cyc_done",  done,  m_done);
      check("cyc_busy",  busy,  m_busy);
      check("cyc_flags", flags, m_flags);
      if (out_en) check("cyc_bus", data_bus, hi_sel ? m_hi : m_res);
      else if (!tb_en) check("cyc_bus_z", data_bus, bus_z);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Present one request for one edge; returns 2ns after that edge
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; acc = a; tb_drv = b; tb_en = 1'b1; out_en = 1'b0;
    cyc();
    start = 1'b0; tb_en = 1'b0;
  endtask

  task automatic expect_res(input string nm, input logic [W-1:0] r, input logic [W-1:0] hi,
                            input logic [3:0] f);
    out_en = 1'b1; hi_sel = 1'b0;
    #1 check({nm, "_res"}, data_bus, r);
    check({nm, "_model_res"}, m_res, r);
    hi_sel = 1'b1;
    #1 check({nm, "_hi"}, data_bus, hi);
    out_en = 1'b0; hi_sel = 1'b0;
    check({nm, "_flags"}, flags, f);
    check({nm, "_model_flags"}, m_flags, f);
  endtask

  task automatic single(input string nm, input logic [3:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] r, input logic [W-1:0] hi,
                        input logic [3:0] f);
    issue(o, a, b);
    check({nm, "_done"}, done, 1'b1);
    check({nm, "_busy"}, busy, 1'b0);
    expect_res(nm, r, hi, f);
    cyc();
    check({nm, "_done_drop"}, done, 1'b0);
  endtask

  task automatic do_mul(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic probe, input logic [W-1:0] r, input logic [W-1:0] hi,
                        input logic [3:0] f);
    int n;
    issue(4'd11, a, b);
    check({nm, "_busy_rise"}, busy, 1'b1);
    check({nm, "_no_early_done"}, done, 1'b0);
    n = 0;
    while (busy && n < 20) begin
      if (probe && n == 3) begin
        start = 1'b1; op = 4'd0; acc = 8'h11; tb_drv = 8'h22; tb_en = 1'b1;
      end else begin
        start = 1'b0; tb_en = 1'b0;
      end
      cyc();
      n++;
    end
    start = 1'b0; tb_en = 1'b0;
    check({nm, "_busy_cycles"}, n, W);
    check({nm, "_done"}, done, 1'b1);
    expect_res(nm, r, hi, f);
    cyc();
    check({nm, "_done_drop"}, done, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int dones;
    start = 1'b0; op = 4'd0; out_en = 1'b0; hi_sel = 1'b0;
    acc = '0; tb_drv = '0; tb_en = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_busy",  busy,  1'b0);
    check("rst_done",  done,  1'b0);
    check("rst_flags", flags, 4'h0);
    check("rst_bus_z", data_bus, bus_z);
    checking = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    cyc();

    single("add_carry", 4'd0,  8'hF0, 8'h20, 8'h10, 8'h00, 4'b0010);
    single("sub_zero",  4'd1,  8'h10, 8'h10, 8'h00, 8'h00, 4'b0001);
    single("add_ovf",   4'd0,  8'h7F, 8'h01, 8'h80, 8'h00, 4'b1100);
    single("dec_zero",  4'd3,  8'h55, 8'h00, 8'hFF, 8'h00, 4'b1010);
    do_mul("mul_small", 8'h0C, 8'h15, 1'b1, 8'hFC, 8'h00, 4'b0000);
    do_mul("mul_max",   8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 4'b1010);
    single("asr_2",     4'd10, 8'h90, 8'h02, 8'hE4, 8'hFE, 4'b1000);
    single("shl_1",     4'd8,  8'h81, 8'h01, 8'h02, 8'hFE, 4'b0010);
    single("shr_9",     4'd9,  8'h81, 8'h09, 8'h00, 8'hFE, 4'b0001);
    single("asr_15",    4'd10, 8'h81, 8'h0F, 8'hFF, 8'hFE, 4'b1010);
    single("rsv_13",    4'd13, 8'h33, 8'h44, 8'hFF, 8'hFE, 4'b1010);
    single("add_5",     4'd0,  8'h02, 8'h03, 8'h05, 8'hFE, 4'b0000);

    // Chained INC: B comes from our own bus drive
    start = 1'b1; op = 4'd2; out_en = 1'b1; hi_sel = 1'b0; tb_en = 1'b0;
    #1 check("chain_pre_bus", data_bus, 8'h05);
    @(posedge clk);
    #2 check("chain_post_bus", data_bus, 8'h06);
    start = 1'b0; out_en = 1'b0;
    check("chain_done",  done,  1'b1);
    check("chain_flags", flags, 4'b0000);
    check("chain_model", m_res, 8'h06);
    cyc();

    // Reset in the middle of a multiply
    issue(4'd11, 8'hFF, 8'hFF);
    cyc();
    reset = 1'b0;
    #1;
    check("mrst_busy",  busy,  1'b0);
    check("mrst_done",  done,  1'b0);
    check("mrst_flags", flags, 4'h0);
    check("mrst_bus_z", data_bus, bus_z);
    cyc();
    out_en = 1'b1; hi_sel = 1'b0;
    #1 check("mrst_res", data_bus, 8'h00);
    hi_sel = 1'b1;
    #1 check("mrst_hi", data_bus, 8'h00);
    out_en = 1'b0; hi_sel = 1'b0;
    cyc();
    reset = 1'b1;
    dones = 0;
    repeat (15) begin
      cyc();
      if (done) dones++;
    end
    check("mrst_no_done", dones, 0);
    check("mrst_idle", busy, 1'b0);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
